button_event_decoder: RTL

- Sits directly downstream of debounce_fsm and consumes its o_debounced_signal; the input is active-high, where 1 means pressed.
- Classifies each press into one of three events: short press, long press or double press.
- Emits each event as a single-cycle pulse for the control logic.
- Thresholds are runtime inputs, sized by a width parameter, the same way debounce_fsm takes its debounce count.

---
 rtl/button_event_decoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Purpose:
//   Classifies presses of a clean, active-high button level (as produced by
//   debounce_fsm) into three events: short press, long press and double
//   press. Each event is reported as a registered single-cycle pulse.
//
//   A single saturating counter is shared between two phases of a press:
//     - while the button is held it counts consecutive high samples, and a
//       long press is declared once it reaches the long threshold;
//     - after a release it counts consecutive low samples, and a short press
//       is declared once it reaches the gap threshold without a second press.
//   A second press that starts inside the gap window produces a double press
//   when it is released, no matter how long it was held.
//
// Parameters:
//   COUNTER_WIDTH       width of both threshold inputs and of the counter
//
// Ports:
//   i_clock             system clock, rising edge
//   i_reset             asynchronous, active-high reset
//   i_long_press_ticks  consecutive high samples that make a press long
//   i_double_gap_ticks  maximum low samples allowed between two presses
//   i_debounced_signal  clean button level, 1 = pressed
//   o_short_press       one-cycle pulse: short press
//   o_long_press        one-cycle pulse: long press
//   o_double_press      one-cycle pulse: double press
//   o_busy              high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [COUNTER_WIDTH-1:0] i_long_press_ticks,
    input  logic [COUNTER_WIDTH-1:0] i_double_gap_ticks,
    input  logic                     i_debounced_signal,
    output logic                     o_short_press,
    output logic                     o_long_press,
    output logic                     o_double_press,
    output logic                     o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_GAP,
        S_SECOND_PRESS
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = '1;

    state_t                   r_state;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_prev;
    logic                     r_short;
    logic                     r_long;
    logic                     r_double;
    logic                     r_busy;

    logic                     w_rise;
    logic [COUNTER_WIDTH-1:0] w_count_inc;
    logic [COUNTER_WIDTH-1:0] w_long_thr;
    logic [COUNTER_WIDTH-1:0] w_gap_thr;
    logic                     w_long_hit;
    logic                     w_gap_hit;

    // A threshold of 0 behaves as 1: an event always needs at least one
    // counted sample behind it.
    assign w_long_thr = (i_long_press_ticks == CNT_ZERO) ? CNT_ONE : i_long_press_ticks;
    assign w_gap_thr  = (i_double_gap_ticks == CNT_ZERO) ? CNT_ONE : i_double_gap_ticks;

    // Saturating increment: a very long hold or gap pins the counter at
    // all-ones instead of wrapping back below the threshold.
    assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;

    // The long check looks at the count including the current high sample;
    // the gap check looks at the low samples already counted. Thresholds are
    // live inputs, so lowering one mid-count takes effect on the next edge.
    assign w_long_hit = (w_count_inc >= w_long_thr);
    assign w_gap_hit  = (r_count >= w_gap_thr);

    assign w_rise = i_debounced_signal & ~r_prev;

    // NOTE: all state below is written with non-blocking assignments so every
    // branch of the case statement sees the values from before this edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_count  <= CNT_ZERO;
            // NOTE: the previous-input register resets to 1, not 0, so a
            // button already held when reset is released does not look like
            // a fresh rising edge; it must be released and pressed again.
            r_prev   <= 1'b1;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_prev   <= i_debounced_signal;

            // Event pulses default low so each one lasts a single cycle.
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_PRESSED;
                        r_count <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_count <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end
                end

                // Counter holds the number of consecutive high samples.
                S_PRESSED: begin
                    if (!i_debounced_signal) begin
                        // The release sample is the first low sample.
                        r_state <= S_WAIT_GAP;
                        r_count <= CNT_ONE;
                    end else if (w_long_hit) begin
                        r_state <= S_LONG_HELD;
                        r_long  <= 1'b1;
                        r_count <= w_count_inc;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end

                // A long press has been reported; its release is silent.
                S_LONG_HELD: begin
                    if (!i_debounced_signal) begin
                        r_state <= S_IDLE;
                        r_count <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end
                end

                // Counter holds the number of consecutive low samples. A
                // second press is tested first, so a press that lands on
                // the same edge as the gap timeout still counts as double.
                S_WAIT_GAP: begin
                    if (i_debounced_signal) begin
                        r_state <= S_SECOND_PRESS;
                        r_count <= CNT_ZERO;
                    end else if (w_gap_hit) begin
                        r_state <= S_IDLE;
                        r_short <= 1'b1;
                        r_count <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end

                // Hold length is deliberately ignored on the second press.
                S_SECOND_PRESS: begin
                    if (!i_debounced_signal) begin
                        r_state  <= S_IDLE;
                        r_double <= 1'b1;
                        r_count  <= CNT_ZERO;
                        r_busy   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_count <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_short_press  = r_short;
    assign o_long_press   = r_long;
    assign o_double_press = r_double;
    assign o_busy         = r_busy;

endmodule
